// File: rtl/button_press_decoder.sv
// Turns a debounced button level into press / long-press / auto-repeat single-cycle events.
// Define AUTO_REPEAT_EN to build the auto-repeat stream; otherwise a long hold latches until release.
module button_press_decoder #(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter int unsigned CNT_W         = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clean,
    output logic press_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
`ifdef AUTO_REPEAT_EN
    localparam logic [1:0] ST_REPEAT  = 2'd2;
`else
    localparam logic [1:0] ST_LATCHED = 2'd2;
`endif

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    // Thresholds below 2 would collapse the hold timer into the press cycle.
    if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("button_press_decoder: LONG_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q;
    logic             rise;
    logic             press_d, long_d;

    assign rise = clean & ~clean_q;

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic repeat_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        press_d  = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!clean) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_REPEAT;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REPEAT: begin
                if (!clean) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REPEAT_LAST) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= repeat_d;
        end
    end
`else
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        long_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!clean) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_LATCHED;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LATCHED: begin
                cnt_d = '0;
                if (!clean) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign repeat_pulse = 1'b0;
`endif

    // clean_q resets high so a button held through reset must be released before it counts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            clean_q     <= 1'b1;
            press_pulse <= 1'b0;
            long_pulse  <= 1'b0;
            held        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clean_q     <= clean;
            press_pulse <= press_d;
            long_pulse  <= long_d;
            held        <= (state_d != ST_IDLE);
        end
    end

endmodule
